// File: rtl/fbuf_port_arbiter.sv
// fbuf_port_arbiter
// Shares the single frame-buffer BRAM port between the VGA reader, the camera
// pixel writer and the processing ALU. VGA has fixed top priority, camera and
// ALU alternate round-robin, and a starvation counter lets the camera preempt
// VGA so that incoming pixels are never dropped.
module fbuf_port_arbiter #(
  parameter int AW     = 19,
  parameter int DW     = 12,
  parameter int RD_LAT = 1,
  parameter int STARVE = 8
) (
  input  logic          sys_clk,
  input  logic          rst,

  input  logic          vga_req,
  input  logic [AW-1:0] vga_addr,
  output logic          vga_gnt,
  output logic          vga_rvalid,
  output logic [DW-1:0] vga_rdata,

  input  logic          cam_req,
  input  logic [AW-1:0] cam_addr,
  input  logic [DW-1:0] cam_wdata,
  output logic          cam_gnt,

  input  logic          alu_req,
  input  logic          alu_we,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] alu_wdata,
  output logic          alu_gnt,
  output logic          alu_rvalid,
  output logic [DW-1:0] alu_rdata,

  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,

  output logic          cam_starved
);

  // Owner of a read travelling through the RAM latency pipeline.
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VGA  = 2'd1,
    TAG_ALU  = 2'd2
  } tag_t;

  // The wait counter is 8 bits wide because STARVE may be as large as 255.
  localparam logic [7:0] STARVE_CNT = 8'(STARVE);

  logic [7:0] wait_cnt;
  logic       starve_hit;
  logic       rr_alu_last;
  tag_t       new_tag;
  tag_t       tag_pipe [0:RD_LAT];

  assign starve_hit = (wait_cnt == STARVE_CNT);

  // Grant selection: starved camera, then VGA, then camera/ALU round-robin.
  // Grants are forced low while reset is held.
  always_comb begin
    vga_gnt = 1'b0;
    cam_gnt = 1'b0;
    alu_gnt = 1'b0;
    if (!rst) begin
      if (cam_req && starve_hit) begin
        cam_gnt = 1'b1;
      end else if (vga_req) begin
        vga_gnt = 1'b1;
      end else if (cam_req && alu_req) begin
        if (rr_alu_last) begin
          cam_gnt = 1'b1;
        end else begin
          alu_gnt = 1'b1;
        end
      end else if (cam_req) begin
        cam_gnt = 1'b1;
      end else if (alu_req) begin
        alu_gnt = 1'b1;
      end
    end
  end

  // Tag for the command being issued this cycle; writes carry no tag.
  always_comb begin
    new_tag = TAG_NONE;
    if (vga_gnt) begin
      new_tag = TAG_VGA;
    end else if (alu_gnt && !alu_we) begin
      new_tag = TAG_ALU;
    end
  end

  // Round-robin pointer: remembers whether the ALU or the camera won last.
  // Reset as "ALU won last" so the camera takes the first tie.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      rr_alu_last <= 1'b1;
    end else if (cam_gnt) begin
      rr_alu_last <= 1'b0;
    end else if (alu_gnt) begin
      rr_alu_last <= 1'b1;
    end
  end

  // Starvation guard: count denied camera cycles, saturate at the threshold,
  // and latch the sticky flag on the edge where the threshold is reached.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= '0;
      cam_starved <= 1'b0;
    end else if (cam_gnt) begin
      wait_cnt <= '0;
    end else if (cam_req && !starve_hit) begin
      wait_cnt <= wait_cnt + 8'd1;
      if (wait_cnt + 8'd1 == STARVE_CNT) begin
        cam_starved <= 1'b1;
      end
    end
  end

  // Memory command register: the winner's command is driven to the RAM in
  // the cycle after its grant. Address/data hold when the port is idle.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= vga_gnt | cam_gnt | alu_gnt;
      mem_we <= cam_gnt | (alu_gnt & alu_we);
      if (cam_gnt) begin
        mem_addr  <= cam_addr;
        mem_wdata <= cam_wdata;
      end else if (vga_gnt) begin
        mem_addr  <= vga_addr;
      end else if (alu_gnt) begin
        mem_addr  <= alu_addr;
        mem_wdata <= alu_wdata;
      end
    end
  end

  // Tag shift register: stage k holds the owner of the read whose command
  // entered the RAM k cycles ago, so stage RD_LAT lines up with mem_rdata.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= RD_LAT; i++) begin
        tag_pipe[i] <= TAG_NONE;
      end
    end else begin
      tag_pipe[0] <= new_tag;
      for (int i = 1; i <= RD_LAT; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  // Read return: capture RAM data for the owning requester and pulse its
  // rvalid for one cycle; rdata holds between returns.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      vga_rvalid <= 1'b0;
      vga_rdata  <= '0;
      alu_rvalid <= 1'b0;
      alu_rdata  <= '0;
    end else begin
      vga_rvalid <= (tag_pipe[RD_LAT] == TAG_VGA);
      alu_rvalid <= (tag_pipe[RD_LAT] == TAG_ALU);
      if (tag_pipe[RD_LAT] == TAG_VGA) begin
        vga_rdata <= mem_rdata;
      end
      if (tag_pipe[RD_LAT] == TAG_ALU) begin
        alu_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_fbuf_port_arbiter.sv
// tb_fbuf_port_arbiter
// Directed bench for the frame-buffer port arbiter with a one-cycle-latency
// RAM model that returns addr[11:0] for locations never written.
module tb_fbuf_port_arbiter;

  localparam int AW = 19;
  localparam int DW = 12;

  logic          sys_clk = 1'b0;
  logic          rst = 1'b1;
  logic          vga_req = 1'b0;
  logic [AW-1:0] vga_addr = '0;
  logic          vga_gnt;
  logic          vga_rvalid;
  logic [DW-1:0] vga_rdata;
  logic          cam_req = 1'b0;
  logic [AW-1:0] cam_addr = '0;
  logic [DW-1:0] cam_wdata = '0;
  logic          cam_gnt;
  logic          alu_req = 1'b0;
  logic          alu_we = 1'b0;
  logic [AW-1:0] alu_addr = '0;
  logic [DW-1:0] alu_wdata = '0;
  logic          alu_gnt;
  logic          alu_rvalid;
  logic [DW-1:0] alu_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          cam_starved;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ram_model [logic [AW-1:0]];

  fbuf_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1), .STARVE(8)) dut (
    .sys_clk(sys_clk), .rst(rst),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
    .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .cam_req(cam_req), .cam_addr(cam_addr), .cam_wdata(cam_wdata),
    .cam_gnt(cam_gnt),
    .alu_req(alu_req), .alu_we(alu_we), .alu_addr(alu_addr),
    .alu_wdata(alu_wdata), .alu_gnt(alu_gnt), .alu_rvalid(alu_rvalid),
    .alu_rdata(alu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cam_starved(cam_starved)
  );

  // 100 MHz-style clock, period 10.
  always #5 sys_clk = ~sys_clk;

  // Single-port RAM with one cycle of read latency.
  always @(posedge sys_clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram_model[mem_addr] = mem_wdata;
      end else if (ram_model.exists(mem_addr)) begin
        mem_rdata <= ram_model[mem_addr];
      end else begin
        mem_rdata <= mem_addr[DW-1:0];
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of requester inputs at the falling edge, then settle.
  task automatic applyStimulus(input logic vr, input logic [AW-1:0] va,
                               input logic cr, input logic [AW-1:0] ca,
                               input logic [DW-1:0] cd,
                               input logic ar, input logic aw,
                               input logic [AW-1:0] aa, input logic [DW-1:0] ad);
    @(negedge sys_clk);
    vga_req = vr; vga_addr = va;
    cam_req = cr; cam_addr = ca; cam_wdata = cd;
    alu_req = ar; alu_we = aw; alu_addr = aa; alu_wdata = ad;
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic doReset();
    @(negedge sys_clk);
    rst = 1'b1;
    vga_req = 1'b0; cam_req = 1'b0; alu_req = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    @(negedge sys_clk);
    #1;
    checkOutput("rst_mem_en", mem_en, 1'b0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_starved", cam_starved, 1'b0);
    checkOutput("rst_vga_rvalid", vga_rvalid, 1'b0);
    rst = 1'b0;

    // Single VGA read of address 5
    applyStimulus(1'b1, 19'd5, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    checkOutput("t1_vga_gnt_c0", vga_gnt, 1'b1);
    checkOutput("t1_cam_gnt_c0", cam_gnt, 1'b0);
    checkOutput("t1_alu_gnt_c0", alu_gnt, 1'b0);
    idleCycle();
    checkOutput("t1_vga_gnt_c1", vga_gnt, 1'b0);
    checkOutput("t1_mem_en_c1", mem_en, 1'b1);
    checkOutput("t1_mem_we_c1", mem_we, 1'b0);
    checkOutput("t1_mem_addr_c1", mem_addr, 19'd5);
    idleCycle();
    checkOutput("t1_mem_en_c2", mem_en, 1'b0);
    checkOutput("t1_vga_rvalid_c2", vga_rvalid, 1'b0);
    idleCycle();
    checkOutput("t1_vga_rvalid_c3", vga_rvalid, 1'b1);
    checkOutput("t1_vga_rdata_c3", vga_rdata, 12'h005);
    checkOutput("t1_alu_rvalid_c3", alu_rvalid, 1'b0);
    idleCycle();
    checkOutput("t1_vga_rvalid_c4", vga_rvalid, 1'b0);
    checkOutput("t1_vga_rdata_hold", vga_rdata, 12'h005);

    // VGA and camera together: VGA first, camera next cycle
    applyStimulus(1'b1, 19'd7, 1'b1, 19'd20, 12'h123, 1'b0, 1'b0, '0, '0);
    checkOutput("t2_vga_gnt_c0", vga_gnt, 1'b1);
    checkOutput("t2_cam_gnt_c0", cam_gnt, 1'b0);
    applyStimulus(1'b0, 19'd7, 1'b1, 19'd20, 12'h123, 1'b0, 1'b0, '0, '0);
    checkOutput("t2_cam_gnt_c1", cam_gnt, 1'b1);
    checkOutput("t2_vga_gnt_c1", vga_gnt, 1'b0);
    checkOutput("t2_mem_addr_c1", mem_addr, 19'd7);
    checkOutput("t2_mem_we_c1", mem_we, 1'b0);
    idleCycle();
    checkOutput("t2_cam_gnt_c2", cam_gnt, 1'b0);
    checkOutput("t2_mem_en_c2", mem_en, 1'b1);
    checkOutput("t2_mem_we_c2", mem_we, 1'b1);
    checkOutput("t2_mem_addr_c2", mem_addr, 19'd20);
    checkOutput("t2_mem_wdata_c2", mem_wdata, 12'h123);
    idleCycle();
    checkOutput("t2_vga_rvalid_c3", vga_rvalid, 1'b1);
    checkOutput("t2_vga_rdata_c3", vga_rdata, 12'h007);

    // Camera and ALU reads contending: strict alternation, camera first
    doReset();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, '0, (i < 6), 19'd30, 12'h777,
                    (i < 6), 1'b0, 19'(40 + i / 2), '0);
      checkOutput($sformatf("t3_cam_gnt_c%0d", i), cam_gnt,
                  (i < 6) && (i % 2 == 0));
      checkOutput($sformatf("t3_alu_gnt_c%0d", i), alu_gnt,
                  (i < 6) && (i % 2 == 1));
      checkOutput($sformatf("t3_alu_rvalid_c%0d", i), alu_rvalid,
                  (i == 4) || (i == 6) || (i == 8));
      if ((i == 4) || (i == 6) || (i == 8)) begin
        checkOutput($sformatf("t3_alu_rdata_c%0d", i), alu_rdata,
                    40 + (i - 4) / 2);
      end
    end

    // VGA saturating the port: camera preempts after 8 denied cycles
    doReset();
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b1, 19'd3, (i <= 8), 19'd50, 12'h0F0,
                    1'b0, 1'b0, '0, '0);
      checkOutput($sformatf("t4_cam_gnt_c%0d", i), cam_gnt, (i == 8));
      checkOutput($sformatf("t4_vga_gnt_c%0d", i), vga_gnt, (i != 8));
      checkOutput($sformatf("t4_starved_c%0d", i), cam_starved, (i >= 8));
      checkOutput($sformatf("t4_wait_cnt_c%0d", i), dut.wait_cnt,
                  (i <= 8) ? i : 0);
    end
    for (int i = 0; i < 4; i++) idleCycle();
    checkOutput("t4_starved_sticky", cam_starved, 1'b1);

    // ALU write then read back of address 100
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b1, 19'd100, 12'hABC);
    checkOutput("t5_alu_gnt_wr", alu_gnt, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0, 19'd100, 12'h000);
    checkOutput("t5_alu_gnt_rd", alu_gnt, 1'b1);
    checkOutput("t5_mem_we_wr", mem_we, 1'b1);
    checkOutput("t5_mem_addr_wr", mem_addr, 19'd100);
    checkOutput("t5_mem_wdata_wr", mem_wdata, 12'hABC);
    for (int i = 2; i < 7; i++) begin
      idleCycle();
      if (i == 2) begin
        checkOutput("t5_mem_we_rd", mem_we, 1'b0);
        checkOutput("t5_mem_en_rd", mem_en, 1'b1);
      end
      checkOutput($sformatf("t5_alu_rvalid_c%0d", i), alu_rvalid, (i == 4));
    end
    checkOutput("t5_alu_rdata", alu_rdata, 12'hABC);

    // Reset one cycle after a VGA grant discards the in-flight read
    applyStimulus(1'b1, 19'd9, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    checkOutput("t6_vga_gnt_c0", vga_gnt, 1'b1);
    @(negedge sys_clk);
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_vga_gnt", vga_gnt, 1'b0);
    checkOutput("t6_rst_mem_en", mem_en, 1'b0);
    checkOutput("t6_rst_mem_addr", mem_addr, 0);
    checkOutput("t6_rst_mem_wdata", mem_wdata, 0);
    checkOutput("t6_rst_starved", cam_starved, 1'b0);
    checkOutput("t6_rst_alu_rdata", alu_rdata, 0);
    checkOutput("t6_rst_vga_rdata", vga_rdata, 0);
    @(negedge sys_clk);
    #1;
    checkOutput("t6_rst_vga_rvalid", vga_rvalid, 1'b0);
    @(negedge sys_clk);
    rst = 1'b0;
    vga_req = 1'b0;
    #1;
    checkOutput("t6_vga_rvalid_c3", vga_rvalid, 1'b0);
    idleCycle();
    checkOutput("t6_vga_rvalid_c4", vga_rvalid, 1'b0);
    idleCycle();
    checkOutput("t6_vga_rvalid_c5", vga_rvalid, 1'b0);
    applyStimulus(1'b1, 19'd12, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    checkOutput("t6_vga_gnt_new", vga_gnt, 1'b1);
    idleCycle();
    checkOutput("t6_mem_addr_new", mem_addr, 19'd12);
    idleCycle();
    checkOutput("t6_vga_rvalid_early", vga_rvalid, 1'b0);
    idleCycle();
    checkOutput("t6_vga_rvalid_new", vga_rvalid, 1'b1);
    checkOutput("t6_vga_rdata_new", vga_rdata, 12'h00C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
